// File: rtl/fifo_sync_param_pkg.sv
// Shared constants for the single-clock FIFO: default widths, derived depth
// and the read-mode encodings.
package fifo_sync_param_pkg;

  localparam int D_LENGTH_DEF = 8;
  localparam int A_LENGTH_DEF = 4;

  localparam int FWFT_STD = 0;
  localparam int FWFT_ON  = 1;

  function automatic int depth_of(input int a_length);
    return 1 << a_length;
  endfunction

  localparam int DEPTH_DEF = depth_of(A_LENGTH_DEF);

endpackage

// File: rtl/fifo_sync_ram.sv
// Simple dual-port RAM: synchronous write, read port either registered
// (with a clearable output register) or asynchronous.
module fifo_sync_ram
  import fifo_sync_param_pkg::*;
#(
  parameter int D_LENGTH   = D_LENGTH_DEF,
  parameter int A_LENGTH   = A_LENGTH_DEF,
  parameter bit ASYNC_READ = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [A_LENGTH-1:0] wr_addr,
  input  logic [D_LENGTH-1:0] wr_data,
  input  logic                rd_en,
  input  logic [A_LENGTH-1:0] rd_addr,
  output logic [D_LENGTH-1:0] rd_data
);

  localparam int DEPTH = depth_of(A_LENGTH);

  logic [D_LENGTH-1:0] mem [DEPTH];
  logic [D_LENGTH-1:0] rd_q;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Output register maps onto the RAM's own synchronous-reset data latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q <= '0;
    end else if (rd_en) begin
      rd_q <= mem[rd_addr];
    end
  end

  assign rd_data = ASYNC_READ ? mem[rd_addr] : rd_q;

endmodule

// File: rtl/fifo_sync_param.sv
// Single-clock parametrised FIFO with runtime almost-full/empty thresholds,
// occupancy count, sticky error flags and standard or FWFT read mode.
module fifo_sync_param
  import fifo_sync_param_pkg::*;
#(
  parameter int D_LENGTH = D_LENGTH_DEF,
  parameter int A_LENGTH = A_LENGTH_DEF,
  parameter int FWFT     = FWFT_STD
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable_wr,
  input  logic [D_LENGTH-1:0] data_in,
  input  logic                enable_rd,
  output logic [D_LENGTH-1:0] data_out,
  output logic                valid_out,
  input  logic [A_LENGTH:0]   af_thresh,
  input  logic [A_LENGTH:0]   ae_thresh,
  output logic [A_LENGTH:0]   fill_count,
  output logic                f_full,
  output logic                f_empty,
  output logic                f_almost_full,
  output logic                f_almost_empty,
  output logic                f_overflow,
  output logic                f_underflow
);

  localparam int CW = A_LENGTH + 1;
  localparam logic [A_LENGTH:0] DEPTH_C = CW'(depth_of(A_LENGTH));
  localparam logic [A_LENGTH:0] ONE_C   = CW'(1);

  logic [A_LENGTH:0] wr_ptr;
  logic [A_LENGTH:0] rd_ptr;
  logic [A_LENGTH:0] count_q;
  logic [A_LENGTH:0] count_next;
  logic [A_LENGTH:0] flag_count;
  logic              wr_acc;
  logic              rd_acc;
  logic              valid_q;
  logic              full_q;
  logic              empty_q;
  logic              afull_q;
  logic              aempty_q;
  logic              ovf_q;
  logic              unf_q;
  logic [D_LENGTH-1:0] ram_rd_data;

  // Requests in the reset cycle are swallowed so nothing reaches the RAM.
  assign wr_acc = enable_wr & ~full_q & ~reset;
  assign rd_acc = enable_rd & ~empty_q & ~reset;

  assign count_next = count_q + CW'(wr_acc) - CW'(rd_acc);
  assign flag_count = reset ? '0 : count_next;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE_C;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ONE_C;
      end
      count_q <= count_next;
      valid_q <= rd_acc;
      if (enable_wr && full_q) begin
        ovf_q <= 1'b1;
      end
      if (enable_rd && empty_q) begin
        unf_q <= 1'b1;
      end
    end
  end

  // Flags follow the same next-count value as fill_count, including on reset.
  always_ff @(posedge clk) begin
    full_q   <= (flag_count == DEPTH_C);
    empty_q  <= (flag_count == '0);
    afull_q  <= (flag_count >= af_thresh);
    aempty_q <= (flag_count <= ae_thresh);
  end

  fifo_sync_ram #(
    .D_LENGTH  (D_LENGTH),
    .A_LENGTH  (A_LENGTH),
    .ASYNC_READ(FWFT == FWFT_ON)
  ) u_ram (
    .clk    (clk),
    .reset  (reset),
    .wr_en  (wr_acc),
    .wr_addr(wr_ptr[A_LENGTH-1:0]),
    .wr_data(data_in),
    .rd_en  (rd_acc),
    .rd_addr(rd_ptr[A_LENGTH-1:0]),
    .rd_data(ram_rd_data)
  );

  assign data_out       = ram_rd_data;
  assign valid_out      = (FWFT == FWFT_ON) ? ~empty_q : valid_q;
  assign fill_count     = count_q;
  assign f_full         = full_q;
  assign f_empty        = empty_q;
  assign f_almost_full  = afull_q;
  assign f_almost_empty = aempty_q;
  assign f_overflow     = ovf_q;
  assign f_underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed bench for fifo_sync_param: a standard-mode and an FWFT instance
// share one stimulus stream; each task checks its own scenario.
module tb_fifo_sync_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_wr;
  logic [7:0] data_in;
  logic       enable_rd;
  logic [4:0] af_thresh;
  logic [4:0] ae_thresh;

  logic [7:0] s_data_out, w_data_out;
  logic       s_valid, w_valid;
  logic [4:0] s_count, w_count;
  logic       s_full, s_empty, s_afull, s_aempty, s_ovf, s_unf;
  logic       w_full, w_empty, w_afull, w_aempty, w_ovf, w_unf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fifo_sync_param #(.D_LENGTH(8), .A_LENGTH(4), .FWFT(0)) dut_std (
    .clk(clk), .reset(reset), .enable_wr(enable_wr), .data_in(data_in),
    .enable_rd(enable_rd), .data_out(s_data_out), .valid_out(s_valid),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .fill_count(s_count),
    .f_full(s_full), .f_empty(s_empty), .f_almost_full(s_afull),
    .f_almost_empty(s_aempty), .f_overflow(s_ovf), .f_underflow(s_unf)
  );

  fifo_sync_param #(.D_LENGTH(8), .A_LENGTH(4), .FWFT(1)) dut_fw (
    .clk(clk), .reset(reset), .enable_wr(enable_wr), .data_in(data_in),
    .enable_rd(enable_rd), .data_out(w_data_out), .valid_out(w_valid),
    .af_thresh(af_thresh), .ae_thresh(ae_thresh), .fill_count(w_count),
    .f_full(w_full), .f_empty(w_empty), .f_almost_full(w_afull),
    .f_almost_empty(w_aempty), .f_overflow(w_ovf), .f_underflow(w_unf)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; enable_wr = 1'b0; enable_rd = 1'b0;
    step();
    reset = 1'b0;
  endtask

  task automatic write_word(input logic [7:0] d);
    enable_wr = 1'b1; data_in = d;
    step();
    enable_wr = 1'b0;
  endtask

  task automatic read_word();
    enable_rd = 1'b1;
    step();
    enable_rd = 1'b0;
  endtask

  task automatic test_reset();
    af_thresh = 5'd0; ae_thresh = 5'd3;
    do_reset();
    checks += 9;
    if (s_count !== 5'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", s_count); end
    if (s_empty !== 1'b1) begin failures++; $display("[TB] FAIL reset_empty got=%b exp=1", s_empty); end
    if (s_full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%b exp=0", s_full); end
    if (s_afull !== 1'b1) begin failures++; $display("[TB] FAIL reset_afull_thr0 got=%b exp=1", s_afull); end
    if (s_aempty !== 1'b1) begin failures++; $display("[TB] FAIL reset_aempty got=%b exp=1", s_aempty); end
    if (s_data_out !== 8'h00) begin failures++; $display("[TB] FAIL reset_data got=%h exp=00", s_data_out); end
    if (s_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid got=%b exp=0", s_valid); end
    if (s_ovf !== 1'b0) begin failures++; $display("[TB] FAIL reset_ovf got=%b exp=0", s_ovf); end
    if (s_unf !== 1'b0) begin failures++; $display("[TB] FAIL reset_unf got=%b exp=0", s_unf); end
    af_thresh = 5'd12;
  endtask

  task automatic test_fill_overflow();
    do_reset();
    for (int i = 0; i < 16; i++) begin
      write_word(8'(i));
      checks++;
      if (s_count !== 5'(i + 1)) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=%0d", s_count, i + 1); end
      if (i == 14) begin
        checks++;
        if (s_full !== 1'b0) begin failures++; $display("[TB] FAIL full_early got=%b exp=0", s_full); end
      end
    end
    checks += 2;
    if (s_full !== 1'b1) begin failures++; $display("[TB] FAIL full_at16 got=%b exp=1", s_full); end
    if (s_ovf !== 1'b0) begin failures++; $display("[TB] FAIL ovf_early got=%b exp=0", s_ovf); end
    write_word(8'hFF);
    checks += 3;
    if (s_ovf !== 1'b1) begin failures++; $display("[TB] FAIL overflow_set got=%b exp=1", s_ovf); end
    if (s_count !== 5'd16) begin failures++; $display("[TB] FAIL overflow_count got=%0d exp=16", s_count); end
    if (s_full !== 1'b1) begin failures++; $display("[TB] FAIL overflow_full got=%b exp=1", s_full); end
  endtask

  task automatic test_drain_std();
    for (int i = 0; i < 16; i++) begin
      read_word();
      checks += 2;
      if (s_data_out !== 8'(i)) begin failures++; $display("[TB] FAIL drain_data got=%h exp=%h", s_data_out, 8'(i)); end
      if (s_valid !== 1'b1) begin failures++; $display("[TB] FAIL drain_valid got=%b exp=1", s_valid); end
      step();
      checks++;
      if (s_valid !== 1'b0) begin failures++; $display("[TB] FAIL valid_pulse got=%b exp=0", s_valid); end
    end
    checks += 2;
    if (s_empty !== 1'b1) begin failures++; $display("[TB] FAIL drain_empty got=%b exp=1", s_empty); end
    if (s_unf !== 1'b0) begin failures++; $display("[TB] FAIL unf_early got=%b exp=0", s_unf); end
    read_word();
    checks += 3;
    if (s_unf !== 1'b1) begin failures++; $display("[TB] FAIL underflow_set got=%b exp=1", s_unf); end
    if (s_valid !== 1'b0) begin failures++; $display("[TB] FAIL underflow_valid got=%b exp=0", s_valid); end
    if (s_data_out !== 8'h0F) begin failures++; $display("[TB] FAIL underflow_hold got=%h exp=0f", s_data_out); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [7:0] q[$];
    logic [7:0] exp_d;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      write_word(8'h10 + 8'(i));
      q.push_back(8'h10 + 8'(i));
    end
    for (int k = 0; k < 40; k++) begin
      enable_wr = 1'b1; enable_rd = 1'b1;
      data_in = 8'h18 + 8'(k);
      q.push_back(data_in);
      exp_d = q.pop_front();
      step();
      checks += 3;
      if (s_data_out !== exp_d) begin failures++; $display("[TB] FAIL wrap_data cyc=%0d got=%h exp=%h", k, s_data_out, exp_d); end
      if (s_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_valid cyc=%0d got=%b exp=1", k, s_valid); end
      if (s_count !== 5'd8) begin failures++; $display("[TB] FAIL wrap_count cyc=%0d got=%0d exp=8", k, s_count); end
    end
    enable_wr = 1'b0; enable_rd = 1'b0;
  endtask

  task automatic test_thresholds();
    af_thresh = 5'd12; ae_thresh = 5'd3;
    do_reset();
    for (int k = 1; k <= 12; k++) begin
      write_word(8'(k));
      checks += 2;
      if (s_aempty !== (k <= 3)) begin failures++; $display("[TB] FAIL ae_up count=%0d got=%b", k, s_aempty); end
      if (s_afull !== (k >= 12)) begin failures++; $display("[TB] FAIL af_up count=%0d got=%b", k, s_afull); end
    end
    for (int k = 11; k >= 3; k--) begin
      read_word();
      checks += 2;
      if (s_aempty !== (k <= 3)) begin failures++; $display("[TB] FAIL ae_down count=%0d got=%b", k, s_aempty); end
      if (s_afull !== (k >= 12)) begin failures++; $display("[TB] FAIL af_down count=%0d got=%b", k, s_afull); end
    end
  endtask

  task automatic test_fwft();
    do_reset();
    write_word(8'hA5);
    checks += 3;
    if (w_data_out !== 8'hA5) begin failures++; $display("[TB] FAIL fwft_data got=%h exp=a5", w_data_out); end
    if (w_empty !== 1'b0) begin failures++; $display("[TB] FAIL fwft_empty got=%b exp=0", w_empty); end
    if (w_valid !== 1'b1) begin failures++; $display("[TB] FAIL fwft_valid got=%b exp=1", w_valid); end
    read_word();
    checks += 3;
    if (w_empty !== 1'b1) begin failures++; $display("[TB] FAIL fwft_pop_empty got=%b exp=1", w_empty); end
    if (w_count !== 5'd0) begin failures++; $display("[TB] FAIL fwft_pop_count got=%0d exp=0", w_count); end
    if (w_valid !== 1'b0) begin failures++; $display("[TB] FAIL fwft_pop_valid got=%b exp=0", w_valid); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 10; i++) write_word(8'h40 + 8'(i));
    checks++;
    if (s_count !== 5'd10) begin failures++; $display("[TB] FAIL mid_count10 got=%0d exp=10", s_count); end
    for (int i = 10; i < 17; i++) write_word(8'h40 + 8'(i));
    read_word();
    read_word();
    checks++;
    if (s_ovf !== 1'b1) begin failures++; $display("[TB] FAIL mid_ovf_set got=%b exp=1", s_ovf); end
    reset = 1'b1; enable_wr = 1'b1; data_in = 8'hEE;
    step();
    reset = 1'b0; enable_wr = 1'b0;
    checks += 8;
    if (s_count !== 5'd0) begin failures++; $display("[TB] FAIL mid_count got=%0d exp=0", s_count); end
    if (s_empty !== 1'b1) begin failures++; $display("[TB] FAIL mid_empty got=%b exp=1", s_empty); end
    if (s_full !== 1'b0) begin failures++; $display("[TB] FAIL mid_full got=%b exp=0", s_full); end
    if (s_afull !== 1'b0) begin failures++; $display("[TB] FAIL mid_afull got=%b exp=0", s_afull); end
    if (s_aempty !== 1'b1) begin failures++; $display("[TB] FAIL mid_aempty got=%b exp=1", s_aempty); end
    if (s_ovf !== 1'b0) begin failures++; $display("[TB] FAIL mid_ovf got=%b exp=0", s_ovf); end
    if (s_valid !== 1'b0) begin failures++; $display("[TB] FAIL mid_valid got=%b exp=0", s_valid); end
    if (s_data_out !== 8'h00) begin failures++; $display("[TB] FAIL mid_data got=%h exp=00", s_data_out); end
    step();
    checks += 2;
    if (s_count !== 5'd0) begin failures++; $display("[TB] FAIL mid_write_ignored got=%0d exp=0", s_count); end
    if (w_empty !== 1'b1) begin failures++; $display("[TB] FAIL mid_fw_empty got=%b exp=1", w_empty); end
  endtask

  initial begin
    reset = 1'b0; enable_wr = 1'b0; enable_rd = 1'b0; data_in = '0;
    af_thresh = '0; ae_thresh = '0;
    #2;
    test_reset();
    test_fill_overflow();
    test_drain_std();
    test_back_to_back_wrap();
    test_thresholds();
    test_fwft();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Single-clock, parametrised synchronous FIFO. Next generation of the team's FIFO top; used where producer and consumer share one clock, so no pointer synchronisers are needed.
- Adds the following over the dual-clock version:
  - runtime almost-full and almost-empty thresholds;
  - an occupancy count output;
  - sticky overflow and underflow error flags;
  - selectable standard or first-word-fall-through (FWFT) read mode.
- Storage is an inferred RAM of 2^A_LENGTH words, targeting Spartan 3E distributed or block RAM.

Parameters:
- D_LENGTH, 8: data word width in bits.
- A_LENGTH, 4: address width. DEPTH = 2^A_LENGTH words.
- FWFT, 0: read mode. 0 = standard mode, with a registered read and 1-cycle latency. 1 = first-word-fall-through mode.

Ports:
- clk, input, 1: single clock. All logic is rising-edge.
- reset, input, 1: synchronous, active-high reset.
- enable_wr, input, 1: write request.
- data_in, input, D_LENGTH: write data.
- enable_rd, input, 1: read request (in FWFT mode, a pop request).
- data_out, output, D_LENGTH: read data.
- valid_out, output, 1: data_out holds newly read data. Used in standard mode only; tied to !f_empty when FWFT=1.
- af_thresh, input, A_LENGTH+1: almost-full threshold.
- ae_thresh, input, A_LENGTH+1: almost-empty threshold.
- fill_count, output, A_LENGTH+1: current occupancy, range 0..DEPTH.
- f_full, f_empty, f_almost_full, f_almost_empty, output, 1 each: status flags.
- f_overflow, f_underflow, output, 1 each: sticky error flags.

Behaviour:
- Pointers:
  - wr_ptr and rd_ptr are A_LENGTH+1 bits wide. The low A_LENGTH bits address the RAM; the MSB toggles on wrap.
  - fill_count is a registered counter, not a pointer difference.
- Reset (reset=1 at a clk edge):
  - Registers cleared: pointers = 0, fill_count = 0, data_out = 0, valid_out = 0, f_overflow = 0, f_underflow = 0.
  - Flags after reset: f_empty = 1, f_full = 0, f_almost_full = (af_thresh == 0), f_almost_empty = 1.
  - RAM contents are not cleared.
  - Reset mid-operation discards all stored data. A read or write request in the reset cycle is ignored.
- Write acceptance:
  - wr_acc = enable_wr & !f_full.
  - A write while full is dropped and sets f_overflow. Contents and pointers are unchanged.
- Read acceptance:
  - rd_acc = enable_rd & !f_empty.
  - A read while empty is ignored and sets f_underflow.
  - Standard mode: data_out holds its last value and valid_out = 0.
- Simultaneous events:
  - A write and read in the same cycle, with the FIFO neither full nor empty, are both accepted. fill_count is unchanged and both pointers advance.
  - When full: the read is accepted and the write is dropped (overflow).
  - When empty: the write is accepted and the read is rejected (underflow).
  - No write-through bypass.
- fill_count update: fill_count_next = fill_count + wr_acc - rd_acc.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] at that edge.
  - valid_out is high for exactly the following cycle per accepted read.
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr], an asynchronous read, valid whenever f_empty = 0.
  - enable_rd pops the head word.
  - A written word appears on data_out in the cycle after the write edge.
- Flags:
  - All flags are registered and computed from fill_count_next, so they are coherent with fill_count on the same edge.
  - f_full = (count == DEPTH).
  - f_empty = (count == 0).
  - f_almost_full = (count >= af_thresh).
  - f_almost_empty = (count <= ae_thresh).
  - Threshold changes take effect at the next edge.
- Error flags: f_overflow and f_underflow stay set until reset.
- Wrap-around: pointers roll over from 2^(A_LENGTH+1)-1 to 0 with no special handling.

Decomposition:
- Shared header (para.h-style) provides:
  - the `d_length` and `a_length` defaults;
  - a derived DEPTH constant;
  - the mode encodings FWFT_STD = 0 and FWFT_ON = 1.
- One natural sub-module, fifo_sync_ram: a simple dual-port RAM with a synchronous write port and a read port selected by a registered/async read parameter.
- All control, counting and flag logic lives in fifo_sync_param.

Test Plan (all scenarios use D_LENGTH=8, A_LENGTH=4, so DEPTH=16):
1. Reset, then write 16 words 0x00..0x0F with no reads:
   - f_full = 1 after the 16th edge and fill_count = 16.
   - A 17th write of 0xFF sets f_overflow; fill_count stays 16.
2. FWFT=0, from full, read 16 words:
   - data_out = 0x00..0x0F in order, each presented one cycle after enable_rd, with valid_out pulsed.
   - f_empty = 1 after the last read.
   - A further read sets f_underflow and valid_out stays 0.
3. Fill to 8, then 40 cycles of simultaneous write and read:
   - fill_count stays 8.
   - Output order is preserved across the pointer wrap (wr_ptr passes 31 -> 0).
4. af_thresh = 12, ae_thresh = 3, stepping from empty upward:
   - f_almost_empty clears when count reaches 4.
   - f_almost_full sets when count reaches 12.
   - Both revert when stepping back down.
5. FWFT=1:
   - Write 0xA5 into an empty FIFO: data_out = 0xA5 and f_empty = 0 in the next cycle.
   - Assert enable_rd: f_empty = 1 and fill_count = 0 after the edge.
6. Fill to 10, set f_overflow, then pulse reset for 1 cycle during an active write:
   - All counts and flags return to their reset values.
   - The write is ignored and f_overflow = 0.
